pipe_mem_stage: RTL and testbench

//  Memory stage of the static pipeline. Sits directly downstream of the execute stage.

---
 rtl/pipe_mem_stage.sv | 152 +++++++++++++++
 tb/tb_pipe_mem_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_stage.sv
// rtl/pipe_mem_stage.sv - EX/MEM pipeline register with a multi-cycle data-memory handshake
// Aligns byte/half stores and loads, stalls upstream while an access is outstanding.
module pipe_mem_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] EXE_aluc,
  input  logic [31:0] EXE_pc4,
  input  logic [31:0] EXE_rt_reg,
  input  logic        EXE_DMEM_ena,
  input  logic        EXE_DMEM_W_ena,
  input  logic [1:0]  EXE_DMEM_W,
  input  logic [1:0]  EXE_DMEM_R,
  input  logic        EXE_load_store_mux_select,
  input  logic        EXE_RF_W_ena,
  input  logic [4:0]  EXE_RF_waddr,
  input  logic [2:0]  EXE_RF_mux_select,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        MEM_valid,
  output logic [31:0] MEM_aluc,
  output logic [31:0] MEM_pc4,
  output logic [31:0] MEM_rdata,
  output logic        MEM_RF_W_ena,
  output logic [4:0]  MEM_RF_waddr,
  output logic [2:0]  MEM_RF_mux_select,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [1:0]  size_q;
  logic [1:0]  addr_lo_q;
  logic        sext_q;

  logic [1:0]  in_size;
  logic [1:0]  a;
  logic        misaligned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign stall     = (state == ACCESS);
  assign mem_req   = (state == ACCESS);
  assign MEM_valid = (state == DONE);

  always_comb begin
    in_size    = EXE_DMEM_W_ena ? EXE_DMEM_W : EXE_DMEM_R;
    a          = EXE_aluc[1:0];
    misaligned = ((in_size == 2'b01) && a[0]) ||
                 (((in_size == 2'b00) || (in_size == 2'b11)) && (a != 2'b00));
    st_be      = 4'b1111;
    st_wdata   = EXE_rt_reg;
    case (in_size)
      2'b10: begin
        st_be    = 4'b0001 << a;
        st_wdata = {4{EXE_rt_reg[7:0]}};
      end
      2'b01: begin
        st_be    = a[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{EXE_rt_reg[15:0]}};
      end
      default: ;
    endcase
  end

  // Load data is picked from the lane selected by the latched low address bits.
  always_comb begin
    ld_byte = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b10:   ld_data = {{24{sext_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{sext_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      wait_cnt          <= 8'd0;
      size_q            <= 2'b00;
      addr_lo_q         <= 2'b00;
      sext_q            <= 1'b0;
      mem_we            <= 1'b0;
      mem_addr          <= 32'd0;
      mem_wdata         <= 32'd0;
      mem_be            <= 4'd0;
      MEM_aluc          <= 32'd0;
      MEM_pc4           <= 32'd0;
      MEM_rdata         <= 32'd0;
      MEM_RF_W_ena      <= 1'b0;
      MEM_RF_waddr      <= 5'd0;
      MEM_RF_mux_select <= 3'd0;
      mem_err           <= 1'b0;
    end else if (state != ACCESS) begin
      wait_cnt          <= 8'd0;
      size_q            <= in_size;
      addr_lo_q         <= a;
      sext_q            <= EXE_load_store_mux_select;
      mem_we            <= 1'b0;
      mem_addr          <= 32'd0;
      mem_wdata         <= 32'd0;
      mem_be            <= 4'd0;
      MEM_aluc          <= EXE_aluc;
      MEM_pc4           <= EXE_pc4;
      MEM_rdata         <= 32'd0;
      MEM_RF_W_ena      <= in_valid & EXE_RF_W_ena;
      MEM_RF_waddr      <= EXE_RF_waddr;
      MEM_RF_mux_select <= EXE_RF_mux_select;
      if (!in_valid) begin
        state <= IDLE;
      end else if (!EXE_DMEM_ena) begin
        state <= DONE;
      end else if (misaligned) begin
        state        <= DONE;
        MEM_RF_W_ena <= 1'b0;
        mem_err      <= 1'b1;
      end else begin
        state     <= ACCESS;
        mem_we    <= EXE_DMEM_W_ena;
        mem_addr  <= {EXE_aluc[31:2], 2'b00};
        mem_wdata <= EXE_DMEM_W_ena ? st_wdata : 32'd0;
        mem_be    <= EXE_DMEM_W_ena ? st_be : 4'b1111;
      end
    end else begin
      if (mem_ready) begin
        state <= DONE;
        if (!mem_we) MEM_rdata <= ld_data;
      end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
        state        <= DONE;
        MEM_RF_W_ena <= 1'b0;
        mem_err      <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// tb/tb_pipe_mem_stage.sv - table-driven and randomized bench for pipe_mem_stage
module tb_pipe_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] EXE_aluc, EXE_pc4, EXE_rt_reg;
  logic        EXE_DMEM_ena, EXE_DMEM_W_ena;
  logic [1:0]  EXE_DMEM_W, EXE_DMEM_R;
  logic        EXE_load_store_mux_select, EXE_RF_W_ena;
  logic [4:0]  EXE_RF_waddr;
  logic [2:0]  EXE_RF_mux_select;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic        MEM_valid;
  logic [31:0] MEM_aluc, MEM_pc4, MEM_rdata;
  logic        MEM_RF_W_ena;
  logic [4:0]  MEM_RF_waddr;
  logic [2:0]  MEM_RF_mux_select;
  logic        mem_err;

  pipe_mem_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .EXE_aluc(EXE_aluc), .EXE_pc4(EXE_pc4), .EXE_rt_reg(EXE_rt_reg),
    .EXE_DMEM_ena(EXE_DMEM_ena), .EXE_DMEM_W_ena(EXE_DMEM_W_ena),
    .EXE_DMEM_W(EXE_DMEM_W), .EXE_DMEM_R(EXE_DMEM_R),
    .EXE_load_store_mux_select(EXE_load_store_mux_select),
    .EXE_RF_W_ena(EXE_RF_W_ena), .EXE_RF_waddr(EXE_RF_waddr),
    .EXE_RF_mux_select(EXE_RF_mux_select),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .MEM_valid(MEM_valid), .MEM_aluc(MEM_aluc), .MEM_pc4(MEM_pc4), .MEM_rdata(MEM_rdata),
    .MEM_RF_W_ena(MEM_RF_W_ena), .MEM_RF_waddr(MEM_RF_waddr),
    .MEM_RF_mux_select(MEM_RF_mux_select), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mem;
    bit          we;
    logic [1:0]  sz;
    bit          sext;
    bit          rfw;
    logic [31:0] aluc;
    logic [31:0] rt;
    logic [31:0] rdata;
    int          waits;
    bit          mis;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rd;
    int          stalls;
  } vec_t;

  vec_t tbl[10];
  vec_t rv;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   exp_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: size in bytes n, naturally aligned lane base, byte replication, shift/mask/extend.
  task automatic model(inout vec_t v);
    int n, off, base, bits;
    logic [31:0] val, mask;
    n    = (v.sz == 2'b01) ? 2 : (v.sz == 2'b10) ? 1 : 4;
    off  = int'(v.aluc % 4);
    base = off - (off % n);
    bits = 8 * n;
    v.mis = v.mem && ((off % n) != 0);
    v.be  = v.we ? 4'(((1 << n) - 1) << base) : 4'hF;
    v.wd  = '0;
    for (int i = 0; i < 4; i++) v.wd[8*i +: 8] = v.rt[8*(i % n) +: 8];
    v.rd = '0;
    if (v.mem && !v.we && !v.mis) begin
      val  = v.rdata >> (8 * base);
      mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
      val  = val & mask;
      if (v.sext && val[bits-1]) val = val | ~mask;
      v.rd = val;
    end
    v.stalls = (v.mem && !v.mis) ? v.waits + 1 : 0;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int          stalls;
    logic [4:0]  wa;
    logic [2:0]  ms;
    logic [31:0] pc;
    wa = 5'($urandom);
    ms = 3'($urandom);
    pc = $urandom;
    in_valid = 1'b1;
    EXE_aluc = v.aluc;
    EXE_pc4 = pc;
    EXE_rt_reg = v.rt;
    EXE_DMEM_ena = v.mem;
    EXE_DMEM_W_ena = v.we;
    EXE_DMEM_W = v.we ? v.sz : 2'($urandom);
    EXE_DMEM_R = v.we ? 2'($urandom) : v.sz;
    EXE_load_store_mux_select = v.sext;
    EXE_RF_W_ena = v.rfw;
    EXE_RF_waddr = wa;
    EXE_RF_mux_select = ms;
    @(posedge clk); #1;
    stalls = 0;
    while (stall === 1'b1 && stalls < 400) begin
      if (stalls == 0) begin
        chk({tag, "_req"}, mem_req, 1'b1);
        chk({tag, "_we"}, mem_we, v.we);
        chk({tag, "_addr"}, mem_addr, v.aluc & 32'hFFFF_FFFC);
        chk({tag, "_be"}, mem_be, v.be);
        if (v.we) chk({tag, "_wdata"}, mem_wdata, v.wd);
      end
      if (stalls == v.waits) begin
        mem_ready = 1'b1;
        mem_rdata = v.rdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      @(posedge clk); #1;
      stalls++;
    end
    mem_ready = 1'b0;
    exp_err = exp_err | v.mis | (v.mem && !v.mis && v.waits >= 255);
    chk({tag, "_stalls"}, stalls, v.stalls);
    chk({tag, "_req_off"}, mem_req, 1'b0);
    chk({tag, "_valid"}, MEM_valid, 1'b1);
    chk({tag, "_aluc"}, MEM_aluc, v.aluc);
    chk({tag, "_pc4"}, MEM_pc4, pc);
    chk({tag, "_rdata"}, MEM_rdata, v.rd);
    chk({tag, "_rfw"}, MEM_RF_W_ena, v.rfw && !v.mis && !(v.mem && v.waits >= 255));
    chk({tag, "_waddr"}, MEM_RF_waddr, wa);
    chk({tag, "_msel"}, MEM_RF_mux_select, ms);
    chk({tag, "_err"}, mem_err, exp_err);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_err = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; in_valid = 1'b0; EXE_aluc = '0; EXE_pc4 = '0; EXE_rt_reg = '0;
    EXE_DMEM_ena = 1'b0; EXE_DMEM_W_ena = 1'b0; EXE_DMEM_W = '0; EXE_DMEM_R = '0;
    EXE_load_store_mux_select = 1'b0; EXE_RF_W_ena = 1'b0; EXE_RF_waddr = '0;
    EXE_RF_mux_select = '0; mem_rdata = '0; mem_ready = 1'b0;

    //            mem we  sz     sx rfw aluc          rt             rdata          w  mis be      wd             rd             st
    tbl[0] = '{0, 0, 2'b00, 0, 1, 32'h0000_1234, 32'h0,        32'h0,         0, 0, 4'hF,   32'h0,         32'h0,         0};
    tbl[1] = '{1, 1, 2'b10, 0, 0, 32'h0000_0103, 32'hAABB_CCDD, 32'h0,        0, 0, 4'b1000, 32'hDDDD_DDDD, 32'h0,        1};
    tbl[2] = '{1, 0, 2'b01, 1, 1, 32'h0000_0202, 32'h0,        32'h8001_FFFF, 3, 0, 4'hF,   32'h0,         32'hFFFF_8001, 4};
    tbl[3] = '{1, 0, 2'b10, 0, 1, 32'h0000_0001, 32'h0,        32'h0000_80FF, 0, 0, 4'hF,   32'h0,         32'h0000_0080, 1};
    tbl[4] = '{1, 1, 2'b01, 0, 0, 32'h0000_000A, 32'h1234_5678, 32'h0,        1, 0, 4'b1100, 32'h5678_5678, 32'h0,        2};
    tbl[5] = '{1, 1, 2'b00, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        2, 0, 4'hF,   32'hDEAD_BEEF, 32'h0,         3};
    tbl[6] = '{1, 0, 2'b10, 1, 1, 32'h0000_0003, 32'h0,        32'h8011_2233, 0, 0, 4'hF,   32'h0,         32'hFFFF_FF80, 1};
    tbl[7] = '{1, 0, 2'b01, 0, 1, 32'h0000_0000, 32'h0,        32'h1234_ABCD, 1, 0, 4'hF,   32'h0,         32'h0000_ABCD, 2};
    tbl[8] = '{1, 0, 2'b11, 1, 1, 32'h0000_0004, 32'h0,        32'hCAFE_F00D, 0, 0, 4'hF,   32'h0,         32'hCAFE_F00D, 1};
    tbl[9] = '{1, 0, 2'b00, 0, 1, 32'h0000_0006, 32'h0,        32'h0,         0, 1, 4'hF,   32'h0,         32'h0,         0};

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_stall", stall, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", MEM_valid, 1'b0);
    chk("rst_err", mem_err, 1'b0);
    chk("rst_aluc", MEM_aluc, 32'h0);
    chk("rst_be", mem_be, 4'h0);
    chk("rst_rfw", MEM_RF_W_ena, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("tbl%0d", i));

    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bubble_valid", MEM_valid, 1'b0);

    // Aligned word load that never sees ready: times out after 255 stall cycles.
    rv = '{1, 0, 2'b00, 0, 1, 32'h0000_0008, 32'h0, 32'h0, 1000, 0, 4'hF, 32'h0, 32'h0, 255};
    run_op(rv, "timeout");
    chk("timeout_err_seen", mem_err, 1'b1);

    // Reset in the middle of an access abandons it and clears the sticky error.
    in_valid = 1'b1; EXE_DMEM_ena = 1'b1; EXE_DMEM_W_ena = 1'b0; EXE_DMEM_R = 2'b00;
    EXE_aluc = 32'h0000_0020;
    @(posedge clk); #1;
    chk("mid_stall", stall, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_req", mem_req, 1'b0);
    chk("mid_stall_off", stall, 1'b0);
    chk("mid_valid", MEM_valid, 1'b0);
    chk("mid_err", mem_err, 1'b0);
    do_reset();

    for (int i = 0; i < 40; i++) begin
      rv.mem = ($urandom_range(0, 3) != 0);
      rv.we = 1'($urandom);
      rv.sz = 2'($urandom);
      rv.sext = 1'($urandom);
      rv.rfw = 1'($urandom);
      rv.aluc = $urandom;
      rv.rt = $urandom;
      rv.rdata = $urandom;
      rv.waits = $urandom_range(0, 4);
      model(rv);
      run_op(rv, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
